// File: rtl/usb_fifo_writer_if.sv
// Pin and stream bundle for the FT601 transmit-side writer.
// The master modport is the writer; the slave modport is its surroundings.
interface usb_fifo_writer_if #(
   parameter int WIDTH    = 32,
   parameter int BE_WIDTH = WIDTH / 8
);
   logic [WIDTH-1:0]    s_data;
   logic [BE_WIDTH-1:0] s_be;
   logic                s_last;
   logic                s_valid;
   logic                s_ready;
   logic                bus_req;
   logic                bus_grant;
   logic                usb_tx_full;
   logic                usb_wren_l;
   logic [WIDTH-1:0]    usb_data_o;
   logic [BE_WIDTH-1:0] usb_be_o;
   logic                usb_data_oe;

   modport master (
      input  s_data, s_be, s_last, s_valid, bus_grant, usb_tx_full,
      output s_ready, bus_req, usb_wren_l, usb_data_o, usb_be_o, usb_data_oe
   );

   modport slave (
      output s_data, s_be, s_last, s_valid, bus_grant, usb_tx_full,
      input  s_ready, bus_req, usb_wren_l, usb_data_o, usb_be_o, usb_data_oe
   );
endinterface

// File: rtl/usb_fifo_writer.sv
// FPGA->host writer for an FT601-style 245 synchronous FIFO bus: buffers stream
// words in a 2-entry FIFO, wins the shared pins from the arbiter, strobes the words out.
module usb_fifo_writer #(
   parameter int WIDTH      = 32,
   parameter int BE_WIDTH   = WIDTH / 8,
   parameter int MAX_BURST  = 256,
   parameter int TURNAROUND = 1
) (
   input  logic              clk,
   input  logic              rst_l,
   usb_fifo_writer_if.master bus
);
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_TURN    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam int EW = WIDTH + BE_WIDTH + 1;
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND - 1);

   state_t              state_r, state_s;
   logic [EW-1:0]       ent0_r, ent1_r, ent0_s, ent1_s, in_word_s;
   logic [1:0]          count_r, count_s;
   logic [BW-1:0]       burst_r, burst_s;
   logic [TW-1:0]       turn_r, turn_s;
   logic                last_seen_r, last_seen_s;
   logic                push_s, pop_s, wren_l_s;
   logic                s_ready_r, bus_req_r, wren_l_r, oe_r;
   logic [WIDTH-1:0]    data_r;
   logic [BE_WIDTH-1:0] be_r;

   assign bus.s_ready     = s_ready_r;
   assign bus.bus_req     = bus_req_r;
   assign bus.usb_wren_l  = wren_l_r;
   assign bus.usb_data_oe = oe_r;
   assign bus.usb_data_o  = data_r;
   assign bus.usb_be_o    = be_r;

   // Two-entry shift FIFO: entry 0 is always the word presented on the pins.
   always_comb begin
      in_word_s = {bus.s_last, bus.s_be, bus.s_data};
      push_s    = bus.s_valid & s_ready_r;
      pop_s     = (state_r == ST_WRITE) & ~wren_l_r & ~bus.usb_tx_full;
      ent0_s    = ent0_r;
      ent1_s    = ent1_r;
      count_s   = count_r;
      case ({push_s, pop_s})
         2'b10: begin
            if (count_r == 2'd0) begin
               ent0_s = in_word_s;
            end else begin
               ent1_s = in_word_s;
            end
            count_s = count_r + 2'd1;
         end
         2'b01: begin
            ent0_s  = ent1_r;
            count_s = count_r - 2'd1;
         end
         2'b11: begin
            if (count_r == 2'd2) begin
               ent0_s = ent1_r;
               ent1_s = in_word_s;
            end else begin
               ent0_s = in_word_s;
            end
         end
         default: count_s = count_r;
      endcase
   end

   // Tenure sequencing plus the per-tenure burst and end-of-packet bookkeeping.
   always_comb begin
      state_s     = state_r;
      turn_s      = turn_r;
      burst_s     = burst_r;
      last_seen_s = last_seen_r | (push_s & bus.s_last);
      if (push_s && (burst_r != BURST_MAX)) begin
         burst_s = burst_r + BW'(1);
      end else begin
         burst_s = burst_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (count_r != 2'd0) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.bus_grant) begin
               state_s = ST_TURN;
               turn_s  = TURN_LOAD;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_TURN: begin
            if (turn_r == TW'(0)) begin
               state_s = ST_WRITE;
            end else begin
               turn_s = turn_r - TW'(1);
            end
         end
         ST_WRITE: begin
            if (pop_s && ent0_r[EW-1]) begin
               state_s = ST_RELEASE;
            end else if ((burst_r == BURST_MAX) && (count_s == 2'd0)) begin
               state_s = ST_RELEASE;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_RELEASE: begin
            state_s     = ST_IDLE;
            burst_s     = {BW{1'b0}};
            last_seen_s = 1'b0;
         end
         default: state_s = ST_IDLE;
      endcase
      wren_l_s = ~((state_s == ST_WRITE) && (count_s != 2'd0));
   end

   // State and pin registers; every pin is a flop loaded from next-state values.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_r     <= ST_IDLE;
         ent0_r      <= {EW{1'b0}};
         ent1_r      <= {EW{1'b0}};
         count_r     <= 2'd0;
         burst_r     <= {BW{1'b0}};
         turn_r      <= {TW{1'b0}};
         last_seen_r <= 1'b0;
         s_ready_r   <= 1'b0;
         bus_req_r   <= 1'b0;
         wren_l_r    <= 1'b1;
         oe_r        <= 1'b0;
         data_r      <= {WIDTH{1'b0}};
         be_r        <= {BE_WIDTH{1'b0}};
      end else begin
         state_r     <= state_s;
         ent0_r      <= ent0_s;
         ent1_r      <= ent1_s;
         count_r     <= count_s;
         burst_r     <= burst_s;
         turn_r      <= turn_s;
         last_seen_r <= last_seen_s;
         s_ready_r   <= (count_s != 2'd2) && (state_s != ST_RELEASE) &&
                        (burst_s != BURST_MAX) && !last_seen_s;
         bus_req_r   <= (state_s != ST_IDLE);
         wren_l_r    <= wren_l_s;
         oe_r        <= (state_s == ST_TURN) || (state_s == ST_WRITE);
         data_r      <= wren_l_s ? {WIDTH{1'b0}} : ent0_s[WIDTH-1:0];
         be_r        <= wren_l_s ? {BE_WIDTH{1'b0}} : ent0_s[WIDTH +: BE_WIDTH];
      end
   end
endmodule

// File: tb/tb_usb_fifo_writer.sv
// Directed bench for usb_fifo_writer (MAX_BURST=4): a negedge bus model plays source,
// arbiter and USB chip, logs every strobed word, and the main sequence checks the log.
module tb_usb_fifo_writer;
   logic clk = 1'b0;
   logic rst_l;
   int   n_checks = 0;
   int   n_errors = 0;

   usb_fifo_writer_if #(.WIDTH(32), .BE_WIDTH(4)) ifc ();

   usb_fifo_writer #(
      .WIDTH(32), .BE_WIDTH(4), .MAX_BURST(4), .TURNAROUND(1)
   ) dut (
      .clk(clk), .rst_l(rst_l), .bus(ifc.master)
   );

   always #5 clk = ~clk;

   logic [36:0] src_mem [64];
   int          src_wr = 0;
   int          src_rd = 0;
   logic        force_valid = 1'b1;
   logic        last_acc = 1'b0;
   int          req_cyc = 0;
   int          req_rises = 0;
   logic        prev_req = 1'b0;
   logic        prev_oe = 1'b0;
   int          stall_id = 0;
   int          stall_done = 0;
   int          stall_at = 0;
   int          stall_len = 0;
   int          stall_left = 0;
   int          stall_seen = 0;
   logic        stall_kill = 1'b0;
   logic [31:0] stall_exp = 32'h0;
   logic [31:0] wr_data [64];
   logic [3:0]  wr_be [64];
   int          wr_cnt = 0;
   int          cur_ten = 0;
   int          ten_n = 0;
   int          low_cyc = 0;
   int          ten_wr [16];
   logic        ten_req [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d, input logic [3:0] be, input logic last);
      src_mem[src_wr] = {last, be, d};
      src_wr++;
   endtask

   task automatic wait_ten(input int target, input int limit);
      int t;
      t = 0;
      while (ten_n < target && t < limit) begin
         tick();
         t++;
      end
   endtask

   // Bus model: stream source, arbiter (grant ~2 cycles after req), tx_full stalls, write log.
   always @(negedge clk) begin
      if (last_acc) src_rd++;
      if (src_rd != src_wr) begin
         ifc.s_valid = 1'b1;
         {ifc.s_last, ifc.s_be, ifc.s_data} = src_mem[src_rd];
      end else begin
         ifc.s_valid = force_valid;
         ifc.s_last  = 1'b0;
         ifc.s_be    = 4'h0;
         ifc.s_data  = 32'h0;
      end
      last_acc = ifc.s_valid && ifc.s_ready;

      if (ifc.bus_req) begin
         if (req_cyc >= 2) ifc.bus_grant = 1'b1;
         req_cyc++;
      end else begin
         ifc.bus_grant = 1'b0;
         req_cyc = 0;
      end
      if (ifc.bus_req && !prev_req) req_rises++;

      if (stall_id != stall_done && !ifc.usb_wren_l && wr_cnt == stall_at) begin
         stall_done = stall_id;
         stall_left = stall_len;
      end
      if (stall_kill) stall_left = 0;
      ifc.usb_tx_full = (stall_left != 0);
      if (stall_left != 0) begin
         stall_left--;
         stall_seen++;
         chk("stall_wren", 32'(ifc.usb_wren_l), 32'd0);
         chk("stall_hold", ifc.usb_data_o, stall_exp);
      end

      if (!ifc.usb_wren_l && !ifc.usb_tx_full && rst_l) begin
         wr_data[wr_cnt] = ifc.usb_data_o;
         wr_be[wr_cnt]   = ifc.usb_be_o;
         wr_cnt++;
         cur_ten++;
      end
      if (ifc.usb_wren_l) chk("be_idle", 32'(ifc.usb_be_o), 32'd0);
      if (!ifc.usb_wren_l) low_cyc++;
      if (prev_oe && !ifc.usb_data_oe) begin
         ten_wr[ten_n]  = cur_ten;
         ten_req[ten_n] = ifc.bus_req;
         ten_n++;
         cur_ten = 0;
      end
      prev_oe  = ifc.usb_data_oe;
      prev_req = ifc.bus_req;
   end

   initial begin
      int b, l0, s0, r0, tn, t;
      rst_l       = 1'b0;
      force_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready", 32'(ifc.s_ready), 32'd0);
         chk("rst_wren", 32'(ifc.usb_wren_l), 32'd1);
         chk("rst_oe", 32'(ifc.usb_data_oe), 32'd0);
         chk("rst_req", 32'(ifc.bus_req), 32'd0);
      end
      force_valid = 1'b0;
      rst_l       = 1'b1;
      tick();
      chk("idle_ready", 32'(ifc.s_ready), 32'd1);
      chk("idle_data", ifc.usb_data_o, 32'h0);

      // Single word with last
      b = wr_cnt; l0 = low_cyc; tn = ten_n;
      push_word(32'hDEADBEEF, 4'hF, 1'b1);
      wait_ten(tn + 1, 60);
      chk("t1_tenures", ten_n, tn + 1);
      chk("t1_nwr", ten_wr[tn], 32'd1);
      chk("t1_data", wr_data[b], 32'hDEADBEEF);
      chk("t1_be", 32'(wr_be[b]), 32'hF);
      chk("t1_strobes", low_cyc - l0, 32'd1);
      chk("t1_rel_req", 32'(ten_req[tn]), 32'd1);
      chk("t1_req_off", 32'(ifc.bus_req), 32'd0);
      chk("t1_oe_off", 32'(ifc.usb_data_oe), 32'd0);

      // Backpressure on word 2 for three cycles
      b = wr_cnt; tn = ten_n; s0 = stall_seen;
      stall_at = b + 1; stall_len = 3; stall_exp = 32'hA5A5_0001; stall_id++;
      for (int i = 0; i < 4; i++) push_word(32'hA5A5_0000 + 32'(i), 4'hF, (i == 3));
      wait_ten(tn + 1, 80);
      chk("t2_tenures", ten_n, tn + 1);
      chk("t2_nwr", ten_wr[tn], 32'd4);
      chk("t2_stalls", stall_seen - s0, 32'd3);
      for (int i = 0; i < 4; i++) chk("t2_data", wr_data[b + i], 32'hA5A5_0000 + 32'(i));

      // Partial byte enables on the final word
      b = wr_cnt; tn = ten_n;
      push_word(32'h0000_1234, 4'hF, 1'b0);
      push_word(32'h5678_9ABC, 4'hF, 1'b0);
      push_word(32'h0000_00EF, 4'b0011, 1'b1);
      wait_ten(tn + 1, 60);
      chk("t3_nwr", ten_wr[tn], 32'd3);
      chk("t3_be0", 32'(wr_be[b]), 32'hF);
      chk("t3_be1", 32'(wr_be[b + 1]), 32'hF);
      chk("t3_be2", 32'(wr_be[b + 2]), 32'h3);
      chk("t3_data2", wr_data[b + 2], 32'h0000_00EF);

      // Ten-word packet split by MAX_BURST=4
      b = wr_cnt; tn = ten_n; r0 = req_rises;
      for (int i = 0; i < 10; i++) push_word(32'hC000_0000 + 32'(i), 4'hF, (i == 9));
      wait_ten(tn + 3, 400);
      chk("t4_tenures", ten_n, tn + 3);
      chk("t4_ten0", ten_wr[tn], 32'd4);
      chk("t4_ten1", ten_wr[tn + 1], 32'd4);
      chk("t4_ten2", ten_wr[tn + 2], 32'd2);
      chk("t4_req_rises", req_rises - r0, 32'd3);
      for (int i = 0; i < 10; i++) chk("t4_data", wr_data[b + i], 32'hC000_0000 + 32'(i));

      // Reset while WRITE holds two buffered words
      b = wr_cnt; s0 = stall_seen;
      stall_at = b; stall_len = 1000; stall_exp = 32'h7777_0000; stall_id++;
      push_word(32'h7777_0000, 4'hF, 1'b0);
      push_word(32'h7777_0001, 4'hF, 1'b0);
      t = 0;
      while (stall_seen - s0 < 3 && t < 80) begin
         tick();
         t++;
      end
      chk("t5_stalled", 32'(stall_seen - s0 >= 3), 32'd1);
      chk("t5_ready_full", 32'(ifc.s_ready), 32'd0);
      rst_l = 1'b0; stall_kill = 1'b1;
      tick();
      chk("t5_oe", 32'(ifc.usb_data_oe), 32'd0);
      chk("t5_wren", 32'(ifc.usb_wren_l), 32'd1);
      chk("t5_req", 32'(ifc.bus_req), 32'd0);
      chk("t5_be", 32'(ifc.usb_be_o), 32'd0);
      rst_l = 1'b1; stall_kill = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("t5_no_writes", wr_cnt, b);
      chk("t5_empty_idle", 32'(ifc.bus_req), 32'd0);
      chk("t5_ready_back", 32'(ifc.s_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
